// File: rtl/adc_frame_tx.sv
// adc_frame_tx
// Turns a 4-digit BCD ADC reading into a 9-byte ASCII frame such as
// "1.234 V\r\n" and writes it one byte at a time into the UART TX FIFO.
// A new frame is produced every FRAME_PERIOD idle cycles.
// All outputs come straight from flops, so there is no input-to-output
// combinational path.

module adc_frame_tx #(
  parameter int          FRAME_PERIOD = 10_000_000,
  parameter logic [7:0]  UNIT_CHAR    = 8'h56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy
);

  // Counter is just wide enough to hold FRAME_PERIOD-1.
  localparam int         CNT_W    = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [3:0] LAST_IDX = 4'd8;

  // Fixed frame characters.
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] periodCnt_q;
  logic [3:0]       byteIdx_q;
  logic [15:0]      snapshot_q;
  logic             wrUart_q;
  logic [7:0]       wData_q;
  logic             busy_q;
  logic [7:0]       frameByte_d;

  // A BCD digit becomes its ASCII character; anything that is not a
  // valid decimal digit is shown as '?' so a broken reading is visible
  // on the terminal instead of printing garbage.
  function automatic logic [7:0] bcdToAscii(input logic [3:0] nibble);
    if (nibble <= 4'd9) begin
      return CH_ZERO + {4'h0, nibble};
    end
    return CH_QMARK;
  endfunction

  // Selects the frame byte for the current index from the frozen snapshot.
  always_comb begin
    frameByte_d = 8'h00;
    case (byteIdx_q)
      4'd0:    frameByte_d = bcdToAscii(snapshot_q[15:12]);
      4'd1:    frameByte_d = CH_DOT;
      4'd2:    frameByte_d = bcdToAscii(snapshot_q[11:8]);
      4'd3:    frameByte_d = bcdToAscii(snapshot_q[7:4]);
      4'd4:    frameByte_d = bcdToAscii(snapshot_q[3:0]);
      4'd5:    frameByte_d = CH_SPACE;
      4'd6:    frameByte_d = UNIT_CHAR;
      4'd7:    frameByte_d = CH_CR;
      4'd8:    frameByte_d = CH_LF;
      default: frameByte_d = 8'h00;
    endcase
  end

  // Frame sequencer: waits out the idle period, freezes the reading, then
  // alternates SEND/GAP so the FIFO full flag has a cycle to catch up with
  // each write before the next byte is considered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      periodCnt_q <= '0;
      byteIdx_q   <= 4'd0;
      snapshot_q  <= 16'h0000;
      wrUart_q    <= 1'b0;
      wData_q     <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      wrUart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (periodCnt_q == CNT_LAST) begin
            periodCnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end else begin
            periodCnt_q <= periodCnt_q + 1'b1;
          end
        end

        LOAD: begin
          snapshot_q <= in;
          byteIdx_q  <= 4'd0;
          state_q    <= SEND;
        end

        SEND: begin
          if (byteIdx_q > LAST_IDX) begin
            byteIdx_q   <= 4'd0;
            periodCnt_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (!tx_full) begin
            wrUart_q <= 1'b1;
            wData_q  <= frameByte_d;
            state_q  <= GAP;
          end
        end

        GAP: begin
          if (byteIdx_q >= LAST_IDX) begin
            byteIdx_q   <= 4'd0;
            periodCnt_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            byteIdx_q <= byteIdx_q + 4'd1;
            state_q   <= SEND;
          end
        end

        default: begin
          byteIdx_q   <= 4'd0;
          periodCnt_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign wr_uart = wrUart_q;
  assign w_data  = wData_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// tb_adc_frame_tx
// Self-checking bench for adc_frame_tx with a short frame period.
// Expected bytes go into a scoreboard queue when a reading is applied and
// are popped by a monitor on every write strobe.

module tb_adc_frame_tx;

  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_full = 1'b0;
  logic [15:0] inVal = 16'h0000;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int relBase = 0;
  int busyFallCyc = -1;
  int pulseCyc[$];
  logic [7:0] expQ[$];
  bit prevWr = 1'b0;
  bit prevBusy = 1'b0;

  typedef struct {
    logic [15:0] stim;
    logic [7:0]  exp [9];
  } vec_t;

  vec_t vecs [4];
  int   frameStart [4];

  adc_frame_tx #(
    .FRAME_PERIOD(FP),
    .UNIT_CHAR(8'h56)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(inVal),
    .tx_full(tx_full),
    .w_data(w_data),
    .wr_uart(wr_uart),
    .busy(busy)
  );

  // 100 MHz-style clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] reading, input logic full);
    inVal   = reading;
    tx_full = full;
  endtask

  task automatic pushBytes(input logic [7:0] b [9]);
    for (int k = 0; k < 9; k++) begin
      expQ.push_back(b[k]);
    end
  endtask

  task automatic pushReading(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] b [9];
    b = '{d0, 8'h2E, d1, d2, d3, 8'h20, 8'h56, 8'h0D, 8'h0A};
    pushBytes(b);
  endtask

  task automatic waitPulses(input int target, input int budget);
    int n = 0;
    while (pulseCyc.size() < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (pulseCyc.size() < target) begin
      checkOutput("pulse_timeout", pulseCyc.size(), target);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (busy) begin
      checkOutput("idle_timeout", busy, 0);
    end
  endtask

  // Monitor: counts edges, checks every strobe against the scoreboard and
  // against the no-back-to-back rule, and logs pulse and busy-fall times.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) begin
      prevWr   = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (wr_uart) begin
        checkOutput("no_adjacent_wr", prevWr, 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", {1'b0, w_data}, 9'h100);
        end else begin
          checkOutput("frame_byte", w_data, expQ.pop_front());
        end
        pulseCyc.push_back(cyc);
      end
      if (prevBusy && !busy) begin
        busyFallCyc = cyc;
      end
      prevWr   = wr_uart;
      prevBusy = busy;
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int p2;

    vecs[0].stim = 16'h1234;
    vecs[0].exp  = '{8'h31, 8'h2E, 8'h32, 8'h33, 8'h34, 8'h20, 8'h56, 8'h0D, 8'h0A};
    vecs[1].stim = 16'hA90F;
    vecs[1].exp  = '{8'h3F, 8'h2E, 8'h39, 8'h30, 8'h3F, 8'h20, 8'h56, 8'h0D, 8'h0A};
    vecs[2].stim = 16'h0000;
    vecs[2].exp  = '{8'h30, 8'h2E, 8'h30, 8'h30, 8'h30, 8'h20, 8'h56, 8'h0D, 8'h0A};
    vecs[3].stim = 16'h9BC5;
    vecs[3].exp  = '{8'h39, 8'h2E, 8'h3F, 8'h3F, 8'h35, 8'h20, 8'h56, 8'h0D, 8'h0A};

    // Reset state.
    #1 rst = 1'b0;
    applyStimulus(vecs[0].stim, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_wr_uart", wr_uart, 0);
    checkOutput("reset_w_data", w_data, 8'h00);
    checkOutput("reset_busy", busy, 0);

    @(negedge clk);
    rst = 1'b1;
    relBase = cyc + 1;

    // Table-driven frames, back to back.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        waitIdle();
        applyStimulus(vecs[i].stim, 1'b0);
      end
      base = pulseCyc.size();
      pushBytes(vecs[i].exp);
      waitPulses(base + 9, 80);
      frameStart[i] = pulseCyc[base];
      if (i == 0) begin
        checkOutput("first_pulse_cycle", frameStart[0] - relBase, FP + 1);
      end else begin
        checkOutput("frame_spacing", frameStart[i] - frameStart[i-1], FP + 19);
      end
      checkOutput("frame_span", pulseCyc[base+8] - pulseCyc[base], 16);
      @(posedge clk);
      #2;
      checkOutput("busy_fall_after_lf", busyFallCyc - pulseCyc[base+8], 1);
      checkOutput("wdata_hold", w_data, 8'h0A);
    end

    // Stall after the second byte for 10 cycles.
    waitIdle();
    applyStimulus(16'h1234, 1'b0);
    base = pulseCyc.size();
    pushReading(8'h31, 8'h32, 8'h33, 8'h34);
    waitPulses(base + 2, 80);
    p2 = pulseCyc[base+1];
    tx_full = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("stall_no_write", pulseCyc.size(), base + 2);
    tx_full = 1'b0;
    waitPulses(base + 3, 10);
    checkOutput("stall_resume_cycle", pulseCyc[base+2] - p2, 11);
    waitPulses(base + 9, 60);

    // Reading changes while a frame is in flight.
    waitIdle();
    applyStimulus(16'h1234, 1'b0);
    base = pulseCyc.size();
    pushReading(8'h31, 8'h32, 8'h33, 8'h34);
    waitPulses(base + 3, 80);
    applyStimulus(16'h9999, 1'b0);
    pushReading(8'h39, 8'h39, 8'h39, 8'h39);
    waitPulses(base + 18, 120);
    checkOutput("midchange_spacing", pulseCyc[base+9] - pulseCyc[base], FP + 19);

    // Asynchronous reset during the fifth byte.
    waitIdle();
    applyStimulus(16'h1234, 1'b0);
    base = pulseCyc.size();
    pushReading(8'h31, 8'h32, 8'h33, 8'h34);
    waitPulses(base + 5, 80);
    #1;
    checkOutput("pre_reset_wr_uart", wr_uart, 1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_wr_uart", wr_uart, 0);
    checkOutput("async_reset_w_data", w_data, 8'h00);
    checkOutput("async_reset_busy", busy, 0);
    expQ.delete();
    applyStimulus(16'h5678, 1'b0);
    pushReading(8'h35, 8'h36, 8'h37, 8'h38);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    relBase = cyc + 1;
    base = pulseCyc.size();
    waitPulses(base + 9, 80);
    checkOutput("post_reset_first_pulse", pulseCyc[base] - relBase, FP + 1);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adc_frame_tx.md
# adc_frame_tx

Formats the 16-bit BCD voltage reading from the integrated ADC stage into an ASCII text frame and pushes it byte-by-byte into the UART transmit FIFO. It sits between the ADC output bus and the `uart` write port (`wr_uart`, `w_data`, `tx_full`) in the 100 MHz domain. Frames are emitted periodically, so a terminal shows a live reading such as `1.234 V`.

## Interface
- FRAME_PERIOD, 10_000_000, number of idle clock cycles between frames (100 ms at 100 MHz); must be ≥ 2
- UNIT_CHAR, 8'h56, ASCII unit character ('V')
- clk  input  1  system clock (100 MHz domain)
- rst  input  1  reset; one clock, reset is asynchronous and active-low
- in  input  16  reading as 4 BCD digits; [15:12] is the most significant (units), [11:8], [7:4], [3:0] follow
- tx_full  input  1  UART TX FIFO full flag
- w_data  output  8  byte to write into the UART FIFO
- wr_uart  output  1  single-cycle write strobe; w_data is valid in the same cycle
- busy  output  1  high while a frame is being captured or sent

## Operation
- Frame is 9 bytes, in this order:
  - ASCII(in[15:12]), '.', ASCII(in[11:8]), ASCII(in[7:4]), ASCII(in[3:0])
  - ' ' (8'h20), UNIT_CHAR, CR (8'h0D), LF (8'h0A)
- Digit conversion: nibble 0–9 maps to 8'h30 + nibble; nibble 10–15 maps to '?' (8'h3F).
- `in` is sampled once per frame in LOAD. Changes to `in` during SEND do not affect the frame in flight.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: period counter increments from 0. When the counter reaches FRAME_PERIOD-1, go to LOAD. busy=0.
  - LOAD: capture `in` into the snapshot register, clear the byte index to 0, go to SEND. busy=1.
  - SEND:
    - If tx_full=0: register wr_uart=1 and w_data=byte[index], then go to GAP.
    - If tx_full=1: stay in SEND with wr_uart=0.
  - GAP: wr_uart=0, one cycle only. This gap lets tx_full reflect the write just issued.
    - If index=8: clear the counter and go to IDLE.
    - Otherwise: increment index and go to SEND.
- Byte index is 4 bits and ranges 0..8. Values 9–15 are unreachable; if ever reached, the block goes to IDLE.
- Period counter width is $clog2(FRAME_PERIOD). It holds at 0 outside IDLE.
- Reset is asynchronous, can arrive mid-frame, and takes effect immediately:
  - state=IDLE, counter=0, index=0, snapshot=0
  - wr_uart=0, w_data=8'h00, busy=0
  - The partial frame is abandoned. After release, the next frame starts from byte 0.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Reset values: wr_uart=0, w_data=8'h00, busy=0.
- First frame, with reset released before cycle 0:
  - IDLE occupies cycles 0..FRAME_PERIOD-1.
  - LOAD is in cycle FRAME_PERIOD.
  - The first wr_uart pulse is visible in cycle FRAME_PERIOD+1.
- With tx_full held at 0:
  - One write occurs every 2 cycles. A frame spans LOAD plus 18 cycles (9 × SEND/GAP).
  - Frame-start to frame-start spacing is FRAME_PERIOD+19 cycles.
- When tx_full is high in SEND, the write is delayed until the first cycle tx_full is low. No byte is skipped or duplicated.
- wr_uart is never high on two consecutive cycles.
- w_data holds its last value while wr_uart=0.
- busy goes to 1 on entry to LOAD and to 0 on entry to IDLE.

## Test plan
- FRAME_PERIOD=4, in=16'h1234, tx_full=0, reset released:
  - Expect 9 pulses carrying 31 2E 32 33 34 20 56 0D 0A.
  - First pulse in cycle 5; pulses are 2 cycles apart.
  - busy goes 1→0 after the LF.
- in=16'hA90F: bytes are 3F 2E 39 30 3F 20 56 0D 0A.
- Hold tx_full=1 for 10 cycles just after the second byte:
  - No wr_uart during the stall.
  - The third byte ('2') is issued in the first cycle after tx_full falls.
  - The total frame is intact.
- Change in from 16'h1234 to 16'h9999 mid-frame: the current frame still sends 1.234; the next frame sends 9.999.
- Assert rst low asynchronously during the 5th byte:
  - Outputs go to reset values without waiting for a clock edge.
  - After release, the next frame begins with byte 0 after FRAME_PERIOD idle cycles.
- Back-to-back frames, FRAME_PERIOD=4: start-to-start spacing is 23 cycles, and wr_uart is never high on adjacent cycles.
